// File: rtl/csr_pkg.sv
// csr_pkg: exception cause codes shared by the csr block and the pipeline/trap handler.
package csr_pkg;
  typedef logic [5:0] ex_code_t;
  localparam ex_code_t EX_CLR   = 6'h00;
  localparam ex_code_t ALU_EX   = 6'h01;
  localparam ex_code_t IL_OP    = 6'h05;
  localparam ex_code_t STACK_OV = 6'h0B;
  localparam ex_code_t SEGFAULT = 6'h12;
  localparam ex_code_t CPU_ERR  = 6'h3E;
  localparam ex_code_t BRKPT    = 6'h3F;
endpackage

// File: rtl/csr_ex_prio.sv
// csr_ex_prio: picks the highest-priority raised event and returns its cause code.
module csr_ex_prio
  import csr_pkg::*;
(
  input  logic [6:0] i_ev,
  output logic       o_valid,
  output ex_code_t   o_code
);
  // i_ev order, high to low: cpu_error, d_seg, i_seg, illegal_op, stack_ov, alu_ex, brkpt
  always_comb begin
    o_valid = |i_ev;
    o_code  = i_ev[6] ? CPU_ERR  :
              i_ev[5] ? SEGFAULT :
              i_ev[4] ? SEGFAULT :
              i_ev[3] ? IL_OP    :
              i_ev[2] ? STACK_OV :
              i_ev[1] ? ALU_EX   :
              i_ev[0] ? BRKPT    : EX_CLR;
  end
endmodule

// File: rtl/csr.sv
// csr: per-thread exception capture; holds the first cause and stalls the thread until cleared.
module csr
  import csr_pkg::*;
#(
  parameter logic [7:0] ID = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_ex,
  input  logic       i_cache_seg_fault,
  input  logic       d_cache_seg_fault,
  input  logic       illegal_op,
  input  logic       alu_op_ex,
  input  logic       stack_overflow,
  input  logic       breakpoint,
  input  logic       cpu_error,
  output logic [5:0] ex_code,
  output logic [7:0] thr_id,
  output logic       csr_stall
);
  ex_code_t r_code;
  logic     r_stall;
  logic     w_valid;
  ex_code_t w_code;
  csr_ex_prio u_prio (
    .i_ev    ({cpu_error, d_cache_seg_fault, i_cache_seg_fault, illegal_op,
               stack_overflow, alu_op_ex, breakpoint}),
    .o_valid (w_valid),
    .o_code  (w_code)
  );
  // clear wins over a same-cycle event; a pending cause is sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code  <= EX_CLR;
      r_stall <= 1'b0;
    end else if (clr_ex) begin
      r_code  <= EX_CLR;
      r_stall <= 1'b0;
    end else if (!r_stall && w_valid) begin
      r_code  <= w_code;
      r_stall <= 1'b1;
    end
  end
  assign ex_code   = r_code;
  assign csr_stall = r_stall;
  assign thr_id    = ID;
endmodule

// File: tb/tb_csr.sv
// tb_csr: directed checks of cause capture, priority, stickiness, clear and async reset.
module tb_csr;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_ex = 1'b0;
  logic [6:0] ev = '0;
  logic [5:0] ex_code;
  logic [7:0] thr_id;
  logic       csr_stall;
  int         n_run = 0;
  int         n_fail = 0;
  csr #(.ID(8'h01)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .clr_ex            (clr_ex),
    .i_cache_seg_fault (ev[4]),
    .d_cache_seg_fault (ev[5]),
    .illegal_op        (ev[3]),
    .alu_op_ex         (ev[1]),
    .stack_overflow    (ev[2]),
    .breakpoint        (ev[0]),
    .cpu_error         (ev[6]),
    .ex_code           (ex_code),
    .thr_id            (thr_id),
    .csr_stall         (csr_stall)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic step(input logic [6:0] e, input logic c);
    @(negedge clk);
    ev = e;
    clr_ex = c;
    @(posedge clk);
    #1;
    ev = '0;
    clr_ex = 1'b0;
  endtask
  task automatic chk_out(input string tag, input logic [7:0] code, input logic stall);
    check({tag, "_code"}, {2'b00, ex_code}, code);
    check({tag, "_stall"}, {7'b0, csr_stall}, {7'b0, stall});
  endtask
  // bit order: 6 cpu_error, 5 d_seg, 4 i_seg, 3 illegal, 2 stack, 1 alu, 0 brk
  logic [6:0] evs  [7] = '{7'b0010000, 7'b0100000, 7'b0000010, 7'b0001000,
                           7'b0000100, 7'b0000001, 7'b1000000};
  logic [7:0] exps [7] = '{8'h12, 8'h12, 8'h01, 8'h05, 8'h0B, 8'h3F, 8'h3E};
  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("thr_id", thr_id, 8'h01);
    chk_out("reset", 8'h00, 1'b0);
    step(7'b0, 1'b1);
    chk_out("clr_idle", 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(evs[i], 1'b0);
      chk_out($sformatf("ev%0d", i), exps[i], 1'b1);
      step(7'b0, 1'b0);
      chk_out($sformatf("ev%0d_hold", i), exps[i], 1'b1);
      step(7'b0, 1'b1);
      chk_out($sformatf("ev%0d_clr", i), 8'h00, 1'b0);
    end
    step(7'b0000010, 1'b0);
    chk_out("sticky_first", 8'h01, 1'b1);
    step(7'b0000001, 1'b0);
    chk_out("sticky_brk", 8'h01, 1'b1);
    step(7'b1000000, 1'b0);
    chk_out("sticky_cpu", 8'h01, 1'b1);
    step(7'b0, 1'b1);
    step(7'b0001011, 1'b0);
    chk_out("prio_il", 8'h05, 1'b1);
    step(7'b0000100, 1'b1);
    chk_out("clr_wins", 8'h00, 1'b0);
    step(7'b0, 1'b0);
    chk_out("clr_wins_after", 8'h00, 1'b0);
    step(7'b1111111, 1'b0);
    chk_out("prio_all", 8'h3E, 1'b1);
    step(7'b0, 1'b1);
    step(7'b0101000, 1'b0);
    chk_out("prio_dseg", 8'h12, 1'b1);
    step(7'b0, 1'b1);
    step(7'b0000011, 1'b0);
    chk_out("prio_alu", 8'h01, 1'b1);
    step(7'b0, 1'b1);
    step(7'b0010000, 1'b0);
    chk_out("pre_rst", 8'h12, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(7'b0, 1'b0);
    chk_out("post_rst", 8'h00, 1'b0);
    check("thr_id_end", thr_id, 8'h01);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
